// File: rtl/msr_pkg.sv
// Shared definitions for the multimode shift register: command encoding and
// the width of the command field.
package msr_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHL   = 3'd1,
    MODE_SHR   = 3'd2,
    MODE_ROTL  = 3'd3,
    MODE_ROTR  = 3'd4,
    MODE_LOAD  = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_RSVD  = 3'd7
  } cmd_mode_e;

endpackage : msr_pkg

// File: rtl/msr_occupancy.sv
// Occupancy tracker for the shift register word array.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   shift_en   - an executing SHL/SHR: count increments, saturating at SIZE
//   load_en    - an executing LOAD: count jumps to SIZE
//   clear_en   - an executing CLEAR: count returns to zero
//   count      - registered number of valid words
//   full/empty - combinational decodes of count
module msr_occupancy #(
  parameter  int unsigned SIZE  = 3,
  localparam int unsigned CNT_W = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             clear_en,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] count_nxt;

  // Next occupancy; the enables are mutually exclusive by construction.
  always_comb begin
    count_nxt = count;
    if (clear_en) begin
      count_nxt = '0;
    end else if (load_en) begin
      count_nxt = CNT_W'(SIZE);
    end else if (shift_en && !full) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign full  = (count == CNT_W'(SIZE));
  assign empty = (count == '0);

endmodule : msr_occupancy

// File: rtl/multimode_shift_register.sv
// Word-wide shift register with shift, rotate, parallel load and clear.
// Ports:
//   clk, rst   - clock and synchronous active-high reset (overrides commands)
//   ce         - clock enable; low freezes all state
//   cmd_valid  - command presented this cycle
//   cmd_mode   - command code (see msr_pkg::cmd_mode_e)
//   data_in    - word entering on SHL (at word 0) or SHR (at word SIZE-1)
//   din        - parallel load image, word i at din[WIDTH*i +: WIDTH]
//   dout       - parallel view of the array, word i at dout[WIDTH*i +: WIDTH]
//   data_out   - last word expelled by a shift while full (registered)
//   out_valid  - one-cycle pulse qualifying data_out
//   count      - number of valid words held
//   full/empty - occupancy decodes of count
module multimode_shift_register
  import msr_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned SIZE  = 3,
  localparam int unsigned CNT_W = $clog2(SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  cmd_valid,
  input  logic [MODE_W-1:0]     cmd_mode,
  input  logic [WIDTH-1:0]      data_in,
  input  logic [WIDTH*SIZE-1:0] din,
  output logic [WIDTH*SIZE-1:0] dout,
  output logic [WIDTH-1:0]      data_out,
  output logic                  out_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  cmd_mode_e        mode;
  logic             exec;
  logic             do_shl;
  logic             do_shr;
  logic             do_rotl;
  logic             do_rotr;
  logic             do_load;
  logic             do_clear;
  logic [WIDTH-1:0] expelled;

  logic [WIDTH-1:0] sr [SIZE];

  // Command decode, qualified by enable and valid.
  always_comb begin
    mode     = cmd_mode_e'(cmd_mode);
    exec     = ce && cmd_valid;
    do_shl   = exec && (mode == MODE_SHL);
    do_shr   = exec && (mode == MODE_SHR);
    do_rotl  = exec && (mode == MODE_ROTL);
    do_rotr  = exec && (mode == MODE_ROTR);
    do_load  = exec && (mode == MODE_LOAD);
    do_clear = exec && (mode == MODE_CLEAR);
  end

  // Word array: each word picks its neighbour (or an external source) per mode.
  for (genvar i = 0; i < int'(SIZE); i++) begin : g_word
    localparam int unsigned PREV = (i == 0) ? SIZE - 1 : i - 1;
    localparam int unsigned NEXT = (i == int'(SIZE) - 1) ? 0 : i + 1;

    logic [WIDTH-1:0] shl_src;
    logic [WIDTH-1:0] shr_src;

    if (i == 0) begin : g_shl_edge
      assign shl_src = data_in;
    end else begin : g_shl_mid
      assign shl_src = sr[PREV];
    end

    if (i == int'(SIZE) - 1) begin : g_shr_edge
      assign shr_src = data_in;
    end else begin : g_shr_mid
      assign shr_src = sr[NEXT];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sr[i] <= '0;
      end else if (do_shl) begin
        sr[i] <= shl_src;
      end else if (do_shr) begin
        sr[i] <= shr_src;
      end else if (do_rotl) begin
        sr[i] <= sr[PREV];
      end else if (do_rotr) begin
        sr[i] <= sr[NEXT];
      end else if (do_load) begin
        sr[i] <= din[WIDTH*i +: WIDTH];
      end else if (do_clear) begin
        sr[i] <= '0;
      end
    end

    assign dout[WIDTH*i +: WIDTH] = sr[i];
  end

  // Word leaving the array on the current shift direction.
  always_comb begin
    expelled = do_shr ? sr[0] : sr[SIZE-1];
  end

  // Output stage: out_valid is refreshed every edge so it can only pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (do_shl || do_shr) && full;
      if ((do_shl || do_shr) && full) begin
        data_out <= expelled;
      end
    end
  end

  msr_occupancy #(
    .SIZE (SIZE)
  ) u_occupancy (
    .clk      (clk),
    .rst      (rst),
    .shift_en (do_shl || do_shr),
    .load_en  (do_load),
    .clear_en (do_clear),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

endmodule : multimode_shift_register

// File: tb/tb_multimode_shift_register.sv
// Directed bench for multimode_shift_register at WIDTH=8, SIZE=3.
module tb_multimode_shift_register;
  import msr_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SIZE  = 3;
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ce;
  logic                  cmd_valid;
  logic [MODE_W-1:0]     cmd_mode;
  logic [WIDTH-1:0]      data_in;
  logic [WIDTH*SIZE-1:0] din;
  logic [WIDTH*SIZE-1:0] dout;
  logic [WIDTH-1:0]      data_out;
  logic                  out_valid;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multimode_shift_register #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .data_in   (data_in),
    .din       (din),
    .dout      (dout),
    .data_out  (data_out),
    .out_valid (out_valid),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Apply a command for one edge, then sample just after it.
  task automatic step(input logic v, input logic [MODE_W-1:0] m, input logic [WIDTH-1:0] d);
    cmd_valid = v;
    cmd_mode  = m;
    data_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; din = '0;
    step(1'b1, MODE_SHL, 8'hEE);
    step(1'b1, MODE_SHL, 8'hEE);
    rst = 1'b0;
    step(1'b0, MODE_HOLD, 8'h00);
    vectors++;
    if (dout !== 24'h000000 || count !== 2'd0 || out_valid !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state dout=%h count=%0d ov=%b dout_w=%h required 000000/0/0/00", dout, count, out_valid, data_out);
    end
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags empty=%b full=%b required 1/0", empty, full);
    end
  endtask

  task automatic test_shl_fill();
    logic [WIDTH-1:0]      words [3] = '{8'h11, 8'h22, 8'h33};
    logic [WIDTH*SIZE-1:0] exp_d [3] = '{24'h000011, 24'h001122, 24'h112233};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, MODE_SHL, words[k]);
      vectors++;
      if (dout !== exp_d[k] || count !== CNT_W'(k + 1) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL shl_fill[%0d] dout=%h count=%0d ov=%b required %h/%0d/0", k, dout, count, out_valid, exp_d[k], k + 1);
      end
    end
    vectors++;
    if (full !== 1'b1 || empty !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL shl_full full=%b empty=%b data_out=%h required 1/0/00", full, empty, data_out);
    end
  endtask

  task automatic test_full_shift();
    step(1'b1, MODE_SHL, 8'h44);
    vectors++;
    if (dout !== 24'h223344 || data_out !== 8'h11 || out_valid !== 1'b1 || count !== 2'd3) begin
      errors++;
      $display("FAIL shl_expel dout=%h data_out=%h ov=%b count=%0d required 223344/11/1/3", dout, data_out, out_valid, count);
    end
    step(1'b1, MODE_SHR, 8'h55);
    vectors++;
    if (dout !== 24'h552233 || data_out !== 8'h44 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL shr_expel dout=%h data_out=%h ov=%b required 552233/44/1", dout, data_out, out_valid);
    end
  endtask

  task automatic test_ce_hold();
    ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, MODE_SHL, 8'h99);
      vectors++;
      if (dout !== 24'h552233 || count !== 2'd3 || data_out !== 8'h44 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ce_hold[%0d] dout=%h count=%0d data_out=%h ov=%b required 552233/3/44/0", k, dout, count, data_out, out_valid);
      end
    end
    ce = 1'b1;
    step(1'b1, MODE_HOLD, 8'h99);
    vectors++;
    if (dout !== 24'h552233 || count !== 2'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mode_hold dout=%h count=%0d ov=%b required 552233/3/0", dout, count, out_valid);
    end
    step(1'b1, MODE_RSVD, 8'h99);
    vectors++;
    if (dout !== 24'h552233 || count !== 2'd3 || out_valid !== 1'b0 || data_out !== 8'h44) begin
      errors++;
      $display("FAIL mode_rsvd dout=%h count=%0d ov=%b data_out=%h required 552233/3/0/44", dout, count, out_valid, data_out);
    end
  endtask

  task automatic test_load_rotate();
    din = 24'hA1B2C3;
    step(1'b1, MODE_LOAD, 8'h00);
    vectors++;
    if (dout !== 24'hA1B2C3 || count !== 2'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL load dout=%h count=%0d ov=%b required a1b2c3/3/0", dout, count, out_valid);
    end
    step(1'b1, MODE_ROTL, 8'h00);
    vectors++;
    if (dout !== 24'hB2C3A1 || count !== 2'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rotl1 dout=%h count=%0d ov=%b required b2c3a1/3/0", dout, count, out_valid);
    end
    step(1'b1, MODE_ROTL, 8'h00);
    vectors++;
    if (dout !== 24'hC3A1B2 || count !== 2'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rotl2 dout=%h count=%0d ov=%b required c3a1b2/3/0", dout, count, out_valid);
    end
    step(1'b1, MODE_ROTR, 8'h00);
    vectors++;
    if (dout !== 24'hB2C3A1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rotr dout=%h ov=%b required b2c3a1/0", dout, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, MODE_SHL, 8'h01);
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 8'hB2) begin
      errors++;
      $display("FAIL b2b_first ov=%b data_out=%h required 1/b2", out_valid, data_out);
    end
    step(1'b1, MODE_SHL, 8'h02);
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 8'hC3 || dout !== 24'hA10102) begin
      errors++;
      $display("FAIL b2b_second ov=%b data_out=%h dout=%h required 1/c3/a10102", out_valid, data_out, dout);
    end
    step(1'b0, MODE_SHL, 8'h03);
    vectors++;
    if (out_valid !== 1'b0 || data_out !== 8'hC3 || dout !== 24'hA10102) begin
      errors++;
      $display("FAIL b2b_idle ov=%b data_out=%h dout=%h required 0/c3/a10102", out_valid, data_out, dout);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    step(1'b1, MODE_SHL, 8'h66);
    rst = 1'b0;
    vectors++;
    if (dout !== 24'h000000 || count !== 2'd0 || out_valid !== 1'b0 || data_out !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_priority dout=%h count=%0d ov=%b data_out=%h empty=%b required 000000/0/0/00/1", dout, count, out_valid, data_out, empty);
    end
  endtask

  task automatic test_partial();
    step(1'b1, MODE_SHL, 8'h77);
    vectors++;
    if (dout !== 24'h000077 || count !== 2'd1 || out_valid !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL partial_shl dout=%h count=%0d ov=%b data_out=%h required 000077/1/0/00", dout, count, out_valid, data_out);
    end
    step(1'b1, MODE_SHR, 8'h88);
    vectors++;
    if (dout !== 24'h880000 || count !== 2'd2 || out_valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL partial_shr dout=%h count=%0d ov=%b full=%b required 880000/2/0/0", dout, count, out_valid, full);
    end
  endtask

  task automatic test_clear();
    din = 24'h123456;
    step(1'b1, MODE_LOAD, 8'h00);
    vectors++;
    if (full !== 1'b1 || dout !== 24'h123456) begin
      errors++;
      $display("FAIL clear_preload full=%b dout=%h required 1/123456", full, dout);
    end
    step(1'b1, MODE_CLEAR, 8'h00);
    vectors++;
    if (dout !== 24'h000000 || count !== 2'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear dout=%h count=%0d empty=%b full=%b ov=%b required 000000/0/1/0/0", dout, count, empty, full, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; data_in = '0; din = '0;
    test_reset();
    test_shl_fill();
    test_full_shift();
    test_ce_hold();
    test_load_rotate();
    test_back_to_back();
    test_reset_priority();
    test_partial();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_multimode_shift_register
